// File: rtl/ir_pkg.sv
// Shared types and widths for the impulse-response capture path (loader and buffer).
package ir_pkg;
  localparam int IR_SAMPLE_W       = 16;
  localparam int IR_IDX_W          = 16;
  localparam int IR_IMPULSE_LENGTH = 24000;

  typedef logic signed [IR_SAMPLE_W-1:0] ir_sample_t;
  typedef logic        [IR_IDX_W-1:0]    ir_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ONSET,
    LOAD,
    DONE
  } ir_state_t;

  // |s| with the most negative code saturating to the largest positive one.
  function automatic logic [IR_SAMPLE_W-1:0] abs_sat(input ir_sample_t s);
    logic [IR_SAMPLE_W-1:0] neg;
    neg = ~s + 1'b1;
    if (!s[IR_SAMPLE_W-1])
      return s;
    else if (s == {1'b1, {(IR_SAMPLE_W-1){1'b0}}})
      return {1'b0, {(IR_SAMPLE_W-1){1'b1}}};
    else
      return neg;
  endfunction
endpackage

// File: rtl/onset_detector.sv
// Saturating magnitude vs threshold; combinational hit plus a registered copy
// that marks the cycle the first capture write is on the bus.
module onset_detector
  import ir_pkg::*;
#(
  parameter logic [IR_SAMPLE_W-1:0] THRESHOLD = 16'd2000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  ir_sample_t i_sample,
  output logic       o_hit,
  output logic       o_hit_q
);
  logic [IR_SAMPLE_W-1:0] w_mag;
  logic                   r_hit;

  assign w_mag   = abs_sat(i_sample);
  assign o_hit   = (w_mag >= THRESHOLD);
  assign o_hit_q = r_hit;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_hit <= 1'b0;
    else       r_hit <= i_en & o_hit;
  end
endmodule

// File: rtl/ir_loader.sv
// Arms on start, waits for an acoustic onset, then streams IMPULSE_LENGTH
// samples into the IR buffer as registered index/data/strobe writes.
module ir_loader
  import ir_pkg::*;
#(
  parameter int                     IMPULSE_LENGTH  = IR_IMPULSE_LENGTH,
  parameter logic [IR_SAMPLE_W-1:0] ONSET_THRESHOLD = 16'd2000,
  parameter int                     TIMEOUT_SAMPLES = 48000
) (
  input  logic       audio_clk,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic       abort_in,
  input  ir_sample_t sample_in,
  input  logic       sample_valid_in,
  output ir_idx_t    ir_sample_index,
  output ir_sample_t write_data,
  output logic       write_enable,
  output logic       ir_data_in_valid,
  output logic       impulse_in_memory_complete,
  output logic       busy_out,
  output logic       timeout_out
);
  localparam int TMO_W = $clog2(TIMEOUT_SAMPLES + 1);

  ir_state_t        r_state, w_next;
  ir_idx_t          r_count, r_idx;
  ir_sample_t       r_data;
  logic [TMO_W-1:0] r_tmo;
  logic             r_strobe, r_we, r_timeout;
  logic             w_hit, w_hit_q;
  logic             w_in_wait, w_in_load, w_arm, w_onset, w_fire, w_last, w_quiet, w_tmo;

  assign w_in_wait = (r_state == WAIT_ONSET);
  assign w_in_load = (r_state == LOAD);
  assign w_arm     = ((r_state == IDLE) || (r_state == DONE)) && start_in && !abort_in;
  assign w_onset   = w_in_wait && sample_valid_in && w_hit && !abort_in;
  assign w_fire    = w_onset || (w_in_load && sample_valid_in && !abort_in);
  assign w_last    = w_fire && (r_count == ir_idx_t'(IMPULSE_LENGTH - 1));
  assign w_quiet   = w_in_wait && sample_valid_in && !w_hit && !abort_in;
  assign w_tmo     = w_quiet && (r_tmo == TMO_W'(TIMEOUT_SAMPLES - 1));

  onset_detector #(.THRESHOLD(ONSET_THRESHOLD)) u_onset (
    .i_clk    (audio_clk),
    .i_rst    (rst_in),
    .i_en     (w_in_wait && sample_valid_in && !abort_in),
    .i_sample (sample_in),
    .o_hit    (w_hit),
    .o_hit_q  (w_hit_q)
  );

  always_ff @(posedge audio_clk) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (w_arm) w_next = WAIT_ONSET;
      WAIT_ONSET: begin
        if (w_onset)    w_next = w_last ? DONE : LOAD;
        else if (w_tmo) w_next = IDLE;
      end
      LOAD:       if (w_last) w_next = DONE;
      DONE:       if (w_arm) w_next = WAIT_ONSET;
      default:    w_next = IDLE;
    endcase
    if (abort_in) w_next = IDLE;
  end

  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      r_count   <= '0;
      r_idx     <= '0;
      r_data    <= '0;
      r_tmo     <= '0;
      r_strobe  <= 1'b0;
      r_we      <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_strobe  <= w_fire;
      r_timeout <= w_tmo;
      // The registered onset hit raises the enable on the first write; this
      // term keeps it up through LOAD and across the final strobe.
      r_we      <= (w_in_load && (w_next == LOAD)) || w_last;
      if (w_arm) begin
        r_count <= '0;
        r_tmo   <= '0;
      end else begin
        if (w_fire)  r_count <= r_count + 1'b1;
        if (w_quiet) r_tmo   <= r_tmo + 1'b1;
      end
      if (w_fire) begin
        r_idx  <= r_count;
        r_data <= sample_in;
      end
    end
  end

  assign ir_sample_index            = r_idx;
  assign write_data                 = r_data;
  assign ir_data_in_valid           = r_strobe;
  assign write_enable               = r_we || w_hit_q;
  assign impulse_in_memory_complete = (r_state == DONE);
  assign busy_out                   = w_in_wait || w_in_load;
  assign timeout_out                = r_timeout;
endmodule

// File: tb/tb_ir_loader.sv
// Randomized and directed capture runs scored against a transaction-level model.
module tb_ir_loader;
  localparam int IL  = 8;
  localparam int THR = 100;
  localparam int TMO = 16;

  logic               audio_clk = 1'b0;
  logic               rst_in = 1'b1, start_in = 1'b0, abort_in = 1'b0, sample_valid_in = 1'b0;
  logic signed [15:0] sample_in = '0;
  logic [15:0]        ir_sample_index;
  logic signed [15:0] write_data;
  logic               write_enable, ir_data_in_valid, impulse_in_memory_complete, busy_out, timeout_out;

  ir_loader #(.IMPULSE_LENGTH(IL), .ONSET_THRESHOLD(16'd100), .TIMEOUT_SAMPLES(TMO)) dut (
    .audio_clk                  (audio_clk),
    .rst_in                     (rst_in),
    .start_in                   (start_in),
    .abort_in                   (abort_in),
    .sample_in                  (sample_in),
    .sample_valid_in            (sample_valid_in),
    .ir_sample_index            (ir_sample_index),
    .write_data                 (write_data),
    .write_enable               (write_enable),
    .ir_data_in_valid           (ir_data_in_valid),
    .impulse_in_memory_complete (impulse_in_memory_complete),
    .busy_out                   (busy_out),
    .timeout_out                (timeout_out)
  );

  always #5 audio_clk = ~audio_clk;

  int n_chk = 0, n_err = 0;
  int n_tmo = 0, n_viol = 0;
  int got_idx[$], got_dat[$];
  int exp_idx[$], exp_dat[$], exp_pos[$];
  int stim[$];

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Bus monitor: collect writes and flag enable/strobe misalignment.
  always @(negedge audio_clk) begin
    if (ir_data_in_valid) begin
      got_idx.push_back(int'(ir_sample_index));
      got_dat.push_back(int'(write_data));
      if (!write_enable) n_viol++;
    end
    if (timeout_out) n_tmo++;
    if (write_enable && !busy_out && !ir_data_in_valid) n_viol++;
  end

  task automatic tick();
    @(posedge audio_clk);
    #1;
  endtask

  task automatic send(input int s, input bit ab, input bit st);
    sample_in       = 16'(s);
    sample_valid_in = 1'b1;
    abort_in        = ab;
    start_in        = st;
    tick();
    sample_valid_in = 1'b0;
    abort_in        = 1'b0;
    start_in        = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  function automatic int mag(input int s);
    int a;
    a = (s < 0) ? -s : s;
    return (a > 32767) ? 32767 : a;
  endfunction

  task automatic run(input string tag, input int abort_k, input int start_k);
    bit onset = 0, to = 0, aborted = 0;
    int sub = 0, apos = -1, spos = -1;
    exp_idx.delete(); exp_dat.delete(); exp_pos.delete();
    foreach (stim[i]) begin
      if (to) break;
      if (!onset) begin
        if (mag(stim[i]) >= THR) begin
          onset = 1;
          exp_idx.push_back(0); exp_dat.push_back(stim[i]); exp_pos.push_back(i);
        end else begin
          sub++;
          if (sub == TMO) to = 1;
        end
      end else if (exp_idx.size() < IL) begin
        exp_idx.push_back(exp_idx.size()); exp_dat.push_back(stim[i]); exp_pos.push_back(i);
      end
    end
    if (abort_k >= 0 && abort_k < exp_idx.size()) begin
      aborted = 1;
      apos = exp_pos[abort_k];
    end
    if (start_k > 0 && start_k < exp_idx.size() && (!aborted || start_k < abort_k))
      spos = exp_pos[start_k];
    if (aborted)
      while (exp_idx.size() > abort_k) begin
        void'(exp_idx.pop_back()); void'(exp_dat.pop_back()); void'(exp_pos.pop_back());
      end

    got_idx.delete(); got_dat.delete();
    n_tmo = 0; n_viol = 0;
    start_in = 1'b1; tick(); start_in = 1'b0;
    chk({tag, "_busy_arm"}, int'(busy_out), 1);
    foreach (stim[i]) send(stim[i], i == apos, i == spos);
    repeat (3) tick();

    chk({tag, "_nwr"}, got_idx.size(), exp_idx.size());
    for (int k = 0; k < exp_idx.size() && k < got_idx.size(); k++) begin
      chk($sformatf("%s_idx%0d", tag, k), got_idx[k], exp_idx[k]);
      chk($sformatf("%s_dat%0d", tag, k), got_dat[k], exp_dat[k]);
    end
    chk({tag, "_complete"}, int'(impulse_in_memory_complete), int'(!aborted && exp_idx.size() == IL));
    chk({tag, "_busy_end"}, int'(busy_out), 0);
    chk({tag, "_we_end"}, int'(write_enable), 0);
    chk({tag, "_timeouts"}, n_tmo, int'(to));
    chk({tag, "_we_align"}, n_viol, 0);
  endtask

  task automatic gen_random();
    int p, m;
    logic signed [15:0] r;
    stim.delete();
    p = $urandom_range(0, TMO);
    for (int i = 0; i < p; i++) stim.push_back(int'($urandom_range(0, 2 * THR - 2)) - (THR - 1));
    m = $urandom_range(THR, 32767);
    if ($urandom_range(0, 4) == 0) stim.push_back(-32768);
    else stim.push_back($urandom_range(0, 1) ? -m : m);
    if (p < TMO)
      repeat (IL - 1 + $urandom_range(0, 3)) begin
        r = 16'($urandom);
        stim.push_back(int'(r));
      end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_strobe", int'(ir_data_in_valid), 0);
    chk("rst_we", int'(write_enable), 0);
    chk("rst_complete", int'(impulse_in_memory_complete), 0);
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_timeout", int'(timeout_out), 0);
    chk("rst_index", int'(ir_sample_index), 0);
    rst_in = 1'b0;
    tick();

    stim = '{5, -20, 150, 1, 2, 3, 4, 5, 6, 7};
    run("basic", -1, -1);

    stim.delete();
    repeat (16) stim.push_back(50);
    stim.push_back(150);
    run("timeout", -1, -1);

    stim.delete();
    repeat (15) stim.push_back(99);
    stim.push_back(100);
    for (int k = 1; k < 8; k++) stim.push_back(-k);
    run("thr_edge", -1, -1);

    stim = '{-32768, 1, 2, 3, 4, 5, 6, 7};
    run("neg_full", -1, -1);

    stim = '{5, -20, 150, 1, 2, 3, 4, 5, 6, 7};
    run("abort4", 4, -1);
    run("recapture", -1, -1);
    run("abort_last", IL - 1, -1);
    run("start_in_load", -1, 3);

    start_in = 1'b1; tick(); start_in = 1'b0;
    chk("done_restart_complete", int'(impulse_in_memory_complete), 0);
    chk("done_restart_busy", int'(busy_out), 1);
    abort_in = 1'b1; tick(); abort_in = 1'b0;
    chk("wait_abort_busy", int'(busy_out), 0);

    got_idx.delete(); got_dat.delete();
    start_in = 1'b1; tick(); start_in = 1'b0;
    send(150, 0, 0); send(1, 0, 0); send(2, 0, 0);
    tick(); tick();
    chk("rst_load_pre_nwr", got_idx.size(), 3);
    rst_in = 1'b1; sample_valid_in = 1'b1; sample_in = 16'sd3;
    tick();
    rst_in = 1'b0; sample_valid_in = 1'b0;
    chk("rst_load_strobe", int'(ir_data_in_valid), 0);
    chk("rst_load_we", int'(write_enable), 0);
    chk("rst_load_busy", int'(busy_out), 0);
    chk("rst_load_index", int'(ir_sample_index), 0);
    chk("rst_load_data", int'(write_data), 0);
    chk("rst_load_complete", int'(impulse_in_memory_complete), 0);
    repeat (5) send(500, 0, 0);
    tick(); tick();
    chk("rst_load_post_nwr", got_idx.size(), 3);

    for (int t = 0; t < 14; t++) begin
      gen_random();
      run($sformatf("rnd%0d", t),
          ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, IL - 1)) : -1,
          ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, IL - 1)) : -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ir_loader.md
IR_LOADER -- requirements
Module: ir_loader

Interface
REQ-001 The module SHALL have parameter IMPULSE_LENGTH, default 24000, meaning the number of IR samples written per capture.
REQ-002 The module SHALL have parameter ONSET_THRESHOLD, default 16'd2000, meaning the minimum |sample| that starts a capture.
REQ-003 The module SHALL have parameter TIMEOUT_SAMPLES, default 48000, meaning the maximum number of samples to wait for onset.
REQ-004 The module SHALL have one clock and a synchronous, active-high reset: audio_clk input 1 (system clock), then rst_in input 1 (synchronous active-high reset).
REQ-005 The module SHALL have port start_in, input, 1 bit: a single-cycle pulse that arms a capture.
REQ-006 The module SHALL have port abort_in, input, 1 bit: cancels a capture in progress.
REQ-007 The module SHALL have port sample_in, input, signed 16 bits: the captured microphone sample.
REQ-008 The module SHALL have port sample_valid_in, input, 1 bit: a single-cycle strobe qualifying sample_in.
REQ-009 The module SHALL have port ir_sample_index, output, 16 bits: the buffer write address.
REQ-010 The module SHALL have port write_data, output, signed 16 bits: the buffer write sample.
REQ-011 The module SHALL have port write_enable, output, 1 bit: held high for the whole LOAD state.
REQ-012 The module SHALL have port ir_data_in_valid, output, 1 bit: a single-cycle strobe qualifying index and data.
REQ-013 The module SHALL have port impulse_in_memory_complete, output, 1 bit: level, high while in DONE.
REQ-014 The module SHALL have port busy_out, output, 1 bit: high in WAIT_ONSET or LOAD.
REQ-015 The module SHALL have port timeout_out, output, 1 bit: a single-cycle pulse when no onset is found.

Function
REQ-016 The FSM SHALL have the states IDLE, WAIT_ONSET, LOAD and DONE.
REQ-017 The FSM SHALL go from IDLE or DONE to WAIT_ONSET on start_in, clearing impulse_in_memory_complete and zeroing the index and timeout counters.
REQ-018 start_in SHALL be ignored in WAIT_ONSET and LOAD.
REQ-019 In WAIT_ONSET, each sample_valid_in SHALL compute |sample_in|, with -32768 saturating to 32767; if |sample_in| >= ONSET_THRESHOLD the FSM SHALL enter LOAD, and that same sample SHALL be written at index 0.
REQ-020 In WAIT_ONSET, each sub-threshold valid sample SHALL increment the timeout counter; when the count reaches TIMEOUT_SAMPLES the FSM SHALL return to IDLE and pulse timeout_out for one cycle.
REQ-021 In LOAD, each accepted sample SHALL be written one cycle after its sample_valid_in: ir_sample_index, write_data and ir_data_in_valid are registered, with index and data stable while the strobe is high.
REQ-022 The index SHALL increment after each write; after the write at index IMPULSE_LENGTH-1 the FSM SHALL enter DONE on the same cycle as that strobe, with no wrap and no further writes.
REQ-023 write_enable SHALL rise on the cycle of the first strobe and fall on the cycle after the last strobe.
REQ-024 abort_in SHALL take priority over all other inputs: the FSM goes to IDLE on the next edge, write_enable and ir_data_in_valid go low, and complete stays 0; an abort that coincides with the last sample SHALL suppress that write.
REQ-025 In DONE, impulse_in_memory_complete SHALL stay high until start_in, abort_in or reset.
REQ-026 Samples arriving outside WAIT_ONSET and LOAD SHALL be dropped.

Reset
REQ-027 On rst_in, including during LOAD, the FSM SHALL enter IDLE and all outputs SHALL be 0, with counters cleared; no partial write strobe SHALL follow reset.

Structure
REQ-028 The state enum, the 16-bit sample and index widths, and the default IMPULSE_LENGTH SHALL live in a shared package, ir_pkg, also used by ir_buffer.
REQ-029 The absolute-value and threshold comparison SHALL be a sub-module, onset_detector, that is combinational with a registered hit flag.

Verification (IMPULSE_LENGTH=8, ONSET_THRESHOLD=100, TIMEOUT_SAMPLES=16)
REQ-030 Start, then samples 5, -20 and 150, then 1..7 -> writes of indices 0..7 with data 150, 1..7, one strobe each, then complete=1 and busy=0.
REQ-031 Start, then 16 samples of value 50 -> timeout_out pulses once, FSM returns to IDLE, no strobes.
REQ-032 Onset on sample -32768 -> write_data=-32768 at index 0 and the capture proceeds (saturated abs passes the threshold).
REQ-033 abort_in asserted at index 4 -> no strobe for index 4 or later, write_enable=0 and complete=0; a following start re-captures from index 0.
REQ-034 rst_in during LOAD at index 3 -> all outputs 0 on the next cycle; sample_valid_in afterwards produces no writes.
REQ-035 start_in pulsed during LOAD -> ignored, capture completes normally; start_in in DONE -> complete drops and WAIT_ONSET is entered.
